// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
// Covers FSM states, opcodes, ALU codes and the immediate-format decode.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_decode(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_ITYPE: imm_decode = IMM_I;
      OP_STORE:          imm_decode = IMM_S;
      OP_BRANCH:         imm_decode = IMM_B;
      OP_JAL:            imm_decode = IMM_J;
      default:           imm_decode = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in, enables and selects out.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       retire;
  logic       illegal_instr;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, retire, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, retire, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder; also usable by the single-cycle control unit.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7_5 is an immediate bit for I-type, so only R-type (op5) may sub
          3'b000:  alu_control = (funct7_5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: registered state, outputs decoded combinationally from state and fields.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);
  state_e     state;
  logic       pc_w, mem_w, ir_w, reg_w, ret, illegal;
  logic [1:0] alu_op;
  logic       legal_op;

  always_comb begin
    case (bus.opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECUTER;
            OP_ITYPE:          state <= S_EXECUTEI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_w           = 1'b0;
    mem_w          = 1'b0;
    ir_w           = 1'b0;
    reg_w          = 1'b0;
    ret            = 1'b0;
    illegal        = 1'b0;
    alu_op         = ALUOP_ADD;
    bus.adr_src    = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    case (state)
      S_FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1;
        bus.alu_src_b = 2'b10; bus.result_src = 2'b10;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b01;
        illegal = !legal_op; ret = !legal_op;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01;
      end
      S_MEMREAD: bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = 2'b01; reg_w = 1'b1; ret = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src = 1'b1; mem_w = 1'b1; ret = 1'b1;
      end
      S_EXECUTER: begin
        bus.alu_src_a = 2'b10; alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_w = 1'b1; ret = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b10; alu_op = ALUOP_SUB; ret = 1'b1;
        // funct3[0] flips beq into bne
        pc_w = bus.zero ^ bus.funct3[0];
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; pc_w = 1'b1;
      end
      default: ;
    endcase
  end

  // reset aborts the instruction: no architectural write in the reset cycle
  assign bus.pc_write      = pc_w    & ~reset;
  assign bus.mem_write     = mem_w   & ~reset;
  assign bus.ir_write      = ir_w    & ~reset;
  assign bus.reg_write     = reg_w   & ~reset;
  assign bus.retire        = ret     & ~reset;
  assign bus.illegal_instr = illegal & ~reset;
  assign bus.imm_src       = imm_decode(bus.opcode);

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7_5    (bus.funct7_5),
    .op5         (bus.opcode[5]),
    .alu_control (bus.alu_control)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle table model, directed and random instructions.
module tb_multicycle_controller;
  logic clk;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       retire;
    logic       illegal_instr;
  } ctrl_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_B = 4, K_JAL = 5, K_ILL = 6;

  int    checks = 0;
  int    errors = 0;
  ctrl_t obs [0:7];

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_LW:    op_of = 7'b0000011;
      K_SW:    op_of = 7'b0100011;
      K_R:     op_of = 7'b0110011;
      K_I:     op_of = 7'b0010011;
      K_B:     op_of = 7'b1100011;
      K_JAL:   op_of = 7'b1101111;
      default: op_of = 7'b1111111;
    endcase
  endfunction

  function automatic int instr_len(input int kind);
    case (kind)
      K_LW:    instr_len = 5;
      K_B:     instr_len = 3;
      K_ILL:   instr_len = 2;
      default: instr_len = 4;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic f75, input logic op5);
    case (f3)
      3'b000:  funct_alu = (f75 && op5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  endfunction

  // Expected control word for cycle k of an instruction of the given kind.
  function automatic ctrl_t exp_ctrl(input int kind, input int k, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f75, input logic z);
    ctrl_t e;
    e = '0;
    case (op)
      7'b0100011: e.imm_src = 2'b01;
      7'b1100011: e.imm_src = 2'b10;
      7'b1101111: e.imm_src = 2'b11;
      default:    e.imm_src = 2'b00;
    endcase
    if (k == 0) begin
      e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    end else if (k == 1) begin
      e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
      if (kind == K_ILL) begin e.illegal_instr = 1; e.retire = 1; end
    end else begin
      case (kind)
        K_LW, K_SW: begin
          if (k == 2) begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
          else if (k == 3) begin
            e.adr_src = 1;
            if (kind == K_SW) begin e.mem_write = 1; e.retire = 1; end
          end else begin e.result_src = 2'b01; e.reg_write = 1; e.retire = 1; end
        end
        K_R, K_I: begin
          if (k == 2) begin
            e.alu_src_a = 2'b10;
            e.alu_src_b = (kind == K_I) ? 2'b01 : 2'b00;
            e.alu_control = funct_alu(f3, f75, op[5]);
          end else begin e.reg_write = 1; e.retire = 1; end
        end
        K_B: begin
          e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.retire = 1;
          e.pc_write = f3[0] ? !z : z;
        end
        K_JAL: begin
          if (k == 2) begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
          else begin e.reg_write = 1; e.retire = 1; end
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t s;
    s.pc_write = bus.pc_write;     s.adr_src = bus.adr_src;
    s.mem_write = bus.mem_write;   s.ir_write = bus.ir_write;
    s.reg_write = bus.reg_write;   s.result_src = bus.result_src;
    s.alu_src_a = bus.alu_src_a;   s.alu_src_b = bus.alu_src_b;
    s.imm_src = bus.imm_src;       s.alu_control = bus.alu_control;
    s.retire = bus.retire;         s.illegal_instr = bus.illegal_instr;
    return s;
  endfunction

  // Drives one instruction for len cycles and records the control words; starts just after a rising edge.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [7:0] zbits, input int len);
    for (int k = 0; k < len; k++) begin
      bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.zero = zbits[k];
      @(negedge clk);
      obs[k] = sample();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ctrl_t g, e;
    reset = 1'b1;
    bus.opcode = 7'b1111111; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0; bus.zero = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      g = sample();
      checks++;
      if ({g.pc_write, g.ir_write, g.reg_write, g.mem_write, g.retire, g.illegal_instr} !== 6'b0) begin
        errors++;
        $display("FAIL reset_enables cyc%0d got=%b exp=000000", i,
                 {g.pc_write, g.ir_write, g.reg_write, g.mem_write, g.retire, g.illegal_instr});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    run_instr(7'b1111111, 3'b000, 1'b0, 8'h00, 2);
    checks++;
    if ({obs[0].ir_write, obs[0].pc_write, obs[0].alu_src_b} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_first_fetch got=%b exp=1110", {obs[0].ir_write, obs[0].pc_write, obs[0].alu_src_b});
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_ctrl(K_ILL, k, 7'b1111111, 3'b000, 1'b0, 1'b0);
      checks++;
      if (obs[k] !== e) begin
        errors++;
        $display("FAIL reset_flush cyc%0d got=%h exp=%h", k, obs[k], e);
      end
    end
  endtask

  task automatic test_lw();
    ctrl_t e;
    run_instr(7'b0000011, 3'b010, 1'b0, 8'h00, 5);
    for (int k = 0; k < 5; k++) begin
      e = exp_ctrl(K_LW, k, 7'b0000011, 3'b010, 1'b0, 1'b0);
      checks++;
      if (obs[k] !== e) begin
        errors++;
        $display("FAIL lw cyc%0d got=%h exp=%h", k, obs[k], e);
      end
    end
    checks++;
    if ({obs[4].reg_write, obs[4].retire, obs[4].result_src} !== 4'b1101) begin
      errors++;
      $display("FAIL lw_writeback got=%b exp=1101", {obs[4].reg_write, obs[4].retire, obs[4].result_src});
    end
  endtask

  task automatic test_rtype_sub();
    run_instr(7'b0110011, 3'b000, 1'b1, 8'h00, 4);
    checks++;
    if (obs[2].alu_control !== 3'b001) begin
      errors++;
      $display("FAIL rtype_sub got=%b exp=001", obs[2].alu_control);
    end
    checks++;
    if ({obs[3].reg_write, obs[3].retire} !== 2'b11) begin
      errors++;
      $display("FAIL rtype_wb got=%b exp=11", {obs[3].reg_write, obs[3].retire});
    end
  endtask

  task automatic test_addi();
    run_instr(7'b0010011, 3'b000, 1'b1, 8'h00, 4);
    checks++;
    if ({obs[2].alu_control, obs[2].alu_src_b} !== 5'b00001) begin
      errors++;
      $display("FAIL addi got=%b exp=00001", {obs[2].alu_control, obs[2].alu_src_b});
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_instr(7'b1100011, f3s[i], 1'b0, {8{zs[i]}}, 3);
      checks++;
      if ({obs[2].pc_write, obs[2].retire} !== {pcw[i], 1'b1}) begin
        errors++;
        $display("FAIL branch case%0d got=%b exp=%b", i, {obs[2].pc_write, obs[2].retire}, {pcw[i], 1'b1});
      end
    end
  endtask

  task automatic test_jal();
    run_instr(7'b1101111, 3'b000, 1'b0, 8'h00, 4);
    checks++;
    if ({obs[0].pc_write, obs[1].pc_write, obs[2].pc_write, obs[3].pc_write} !== 4'b1010) begin
      errors++;
      $display("FAIL jal_pc_write got=%b exp=1010",
               {obs[0].pc_write, obs[1].pc_write, obs[2].pc_write, obs[3].pc_write});
    end
    checks++;
    if ({obs[3].reg_write, obs[0].imm_src, obs[1].imm_src, obs[2].imm_src, obs[3].imm_src} !== 9'b1_11111111) begin
      errors++;
      $display("FAIL jal_wb_imm got=%b exp=111111111",
               {obs[3].reg_write, obs[0].imm_src, obs[1].imm_src, obs[2].imm_src, obs[3].imm_src});
    end
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 1'b0, 8'h00, 3);
    checks++;
    if ({obs[1].illegal_instr, obs[1].retire, obs[2].ir_write, obs[2].illegal_instr} !== 4'b1110) begin
      errors++;
      $display("FAIL illegal got=%b exp=1110",
               {obs[1].illegal_instr, obs[1].retire, obs[2].ir_write, obs[2].illegal_instr});
    end
    // third cycle was a fresh FETCH; finish that illegal "instruction" so we realign
    run_instr(7'b1111111, 3'b000, 1'b0, 8'h00, 1);
  endtask

  task automatic test_reset_midinstr();
    ctrl_t g, e;
    run_instr(7'b0100011, 3'b010, 1'b0, 8'h00, 3);
    reset = 1'b1;
    @(negedge clk);
    g = sample();
    checks++;
    if ({g.mem_write, g.retire, g.pc_write, g.ir_write, g.reg_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_memwrite got=%b exp=00000",
               {g.mem_write, g.retire, g.pc_write, g.ir_write, g.reg_write});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(7'b1111111, 3'b000, 1'b0, 8'h00, 2);
    e = exp_ctrl(K_ILL, 0, 7'b1111111, 3'b000, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== e) begin
      errors++;
      $display("FAIL reset_memwrite_fetch got=%h exp=%h", obs[0], e);
    end
  endtask

  task automatic test_random();
    int         kind, len;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic [7:0] zb;
    ctrl_t      e;
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 6));
      op   = op_of(kind);
      if (kind == K_ILL) begin
        do op = 7'($urandom);
        while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111);
      end
      f3  = 3'($urandom);
      if (kind == K_B) f3 = {2'b00, f3[0]};
      f75 = 1'($urandom);
      zb  = 8'($urandom);
      len = instr_len(kind);
      run_instr(op, f3, f75, zb, len);
      for (int k = 0; k < len; k++) begin
        e = exp_ctrl(kind, k, op, f3, f75, zb[k]);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL random n%0d kind%0d op=%b cyc%0d got=%h exp=%h", n, kind, op, k, obs[k], e);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype_sub();
    test_addi();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_midinstr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
